// File: rtl/ps2_cmd_decoder_pkg.sv
// Shared scancode constants, prefix FSM state encoding and the scancode-to-digit
// mapping used by ps2_cmd_decoder and ps2_prefix_fsm.
package ps2_cmd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_R     = 8'h2D;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_BREAK = 2'd1,
    P_EXT   = 2'd2
  } prefix_state_e;

  // Returns {is_digit, digit}; digit is 0 for non-digit codes.
  function automatic logic [4:0] sc_to_digit(input logic [7:0] sc);
    logic [4:0] r;
    unique case (sc)
      SC_D0:   r = {1'b1, 4'd0};
      SC_D1:   r = {1'b1, 4'd1};
      SC_D2:   r = {1'b1, 4'd2};
      SC_D3:   r = {1'b1, 4'd3};
      SC_D4:   r = {1'b1, 4'd4};
      SC_D5:   r = {1'b1, 4'd5};
      SC_D6:   r = {1'b1, 4'd6};
      SC_D7:   r = {1'b1, 4'd7};
      SC_D8:   r = {1'b1, 4'd8};
      SC_D9:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Strips F0 (break) and E0 (extended) prefixes from the PS/2 byte stream and
// emits a combinational make_tick for each make code that should be acted on.
module ps2_prefix_fsm
  import ps2_cmd_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          rx_tick,
  input  logic [7:0]    din,
  output logic          make_tick,
  output logic [7:0]    make_code,
  output logic          is_ext,
  output prefix_state_e state_o
);

  prefix_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= P_IDLE;
    else         state_q <= state_d;
  end

  // Handshake: a byte is consumed only in a cycle where rx_tick is high;
  // make_tick is valid in that same cycle and has no back-pressure.
  always_comb begin
    state_d   = state_q;
    make_tick = 1'b0;
    make_code = din;
    is_ext    = 1'b0;
    if (rx_tick) begin
      unique case (state_q)
        P_IDLE: begin
          if (din == SC_BREAK)    state_d = P_BREAK;
          else if (din == SC_EXT) state_d = P_EXT;
          else                    make_tick = 1'b1;
        end
        P_BREAK: state_d = P_IDLE;
        P_EXT: begin
          state_d = (din == SC_BREAK) ? P_BREAK : P_IDLE;
          // Only keypad Enter is meaningful among extended make codes.
          if (din == SC_ENTER) begin
            make_tick = 1'b1;
            is_ext    = 1'b1;
          end
        end
        default: state_d = P_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 set-2 command decoder: decimal entry with range-checked commit, flags and
// FSM reset pulse. Define ENTRY_TIMEOUT_EN to build the partial-entry timeout.
module ps2_cmd_decoder
  import ps2_cmd_pkg::*;
#(
  parameter int          NUM_DIGITS     = 3,
  parameter int          MAX_VALUE      = 125,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    rx_tick,
  input  logic [7:0]              din,
  output logic [4*NUM_DIGITS-1:0] value_bcd,
  output logic                    value_valid,
  output logic                    commit_tick,
  output logic                    error_tick,
  output logic [2:0]              entry_count,
  output logic [2:0]              flags,
  output logic                    greset,
  output logic                    timeout_tick
);

  localparam int BW = 4 * NUM_DIGITS;

  // MAX_VALUE in BCD, clamped to the largest value the entry can hold.
  function automatic logic [BW-1:0] max_to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   x, lim;
    lim = 1;
    for (int i = 0; i < NUM_DIGITS; i++) lim = lim * 10;
    x = (v >= lim) ? lim - 1 : v;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] MAX_BCD = max_to_bcd(MAX_VALUE);

  // Most significant differing digit decides the ordering.
  function automatic logic bcd_le(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic le, done;
    le   = 1'b1;
    done = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
        done = 1'b1;
        le   = a[4*i +: 4] < b[4*i +: 4];
      end
    end
    return le;
  endfunction

  logic          mk_tick, mk_ext;
  logic [7:0]    mk_code;
  prefix_state_e unused_prefix_state;
  logic [4:0]    dig_info;
  logic          tmo_fire;

  logic [BW-1:0] entry_q, entry_d, value_q, value_d;
  logic [2:0]    count_q, count_d, flags_q, flags_d;
  logic          valid_q, valid_d, commit_q, commit_d, error_q, error_d;
  logic          greset_q, greset_d, tmo_q, tmo_d;

  ps2_prefix_fsm u_prefix (
    .clk_i     (CLK),
    .reset_i   (reset),
    .rx_tick   (rx_tick),
    .din       (din),
    .make_tick (mk_tick),
    .make_code (mk_code),
    .is_ext    (mk_ext),
    .state_o   (unused_prefix_state)
  );

  assign dig_info = sc_to_digit(mk_code);

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tcnt_q;

  always_ff @(posedge CLK) begin
    if (reset)                                  tcnt_q <= '0;
    else if (mk_tick)                           tcnt_q <= '0;
    else if (count_q != 3'd0 && tcnt_q != TMO_LAST) tcnt_q <= tcnt_q + 32'd1;
  end

  assign tmo_fire = !mk_tick && (count_q != 3'd0) && (tcnt_q == TMO_LAST);
`else
  wire timeout_cfg_unused = (TIMEOUT_CYCLES != 0);
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    value_d  = value_q;
    valid_d  = valid_q;
    flags_d  = flags_q;
    commit_d = 1'b0;
    error_d  = 1'b0;
    greset_d = 1'b0;
    tmo_d    = 1'b0;
    if (mk_tick) begin
      if (mk_code == SC_ENTER) begin
        if (count_q != 3'd0) begin
          if (bcd_le(entry_q, MAX_BCD)) begin
            value_d  = entry_q;
            valid_d  = 1'b1;
            commit_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          entry_d = '0;
          count_d = 3'd0;
        end
      end else if (!mk_ext && dig_info[4]) begin
        if (count_q == 3'(NUM_DIGITS)) begin
          error_d = 1'b1;
        end else begin
          entry_d      = entry_q << 4;
          entry_d[3:0] = dig_info[3:0];
          count_d      = count_q + 3'd1;
        end
      end else if (!mk_ext) begin
        unique case (mk_code)
          SC_BKSP: if (count_q != 3'd0) begin
            entry_d = entry_q >> 4;
            count_d = count_q - 3'd1;
          end
          SC_ESC: begin
            entry_d = '0;
            count_d = 3'd0;
          end
          SC_P: flags_d[2] = ~flags_q[2];
          SC_A: flags_d[1] = ~flags_q[1];
          SC_G: flags_d[0] = ~flags_q[0];
          SC_R: begin
            greset_d = 1'b1;
            flags_d  = 3'b000;
            entry_d  = '0;
            count_d  = 3'd0;
          end
          default: ;
        endcase
      end
    end else if (tmo_fire) begin
      entry_d = '0;
      count_d = 3'd0;
      tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      entry_q  <= '0;
      count_q  <= 3'd0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      flags_q  <= 3'b000;
      commit_q <= 1'b0;
      error_q  <= 1'b0;
      greset_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      flags_q  <= flags_d;
      commit_q <= commit_d;
      error_q  <= error_d;
      greset_q <= greset_d;
      tmo_q    <= tmo_d;
    end
  end

  assign value_bcd    = value_q;
  assign value_valid  = valid_q;
  assign commit_tick  = commit_q;
  assign error_tick   = error_q;
  assign entry_count  = count_q;
  assign flags        = flags_q;
  assign greset       = greset_q;
  assign timeout_tick = tmo_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: directed scenarios plus random byte
// streams compared against an integer-valued keypress model.
module tb_ps2_cmd_decoder;

  localparam int ND   = 3;
  localparam int MAXV = 125;
  localparam int TMO  = 100;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        rx_tick = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [11:0] value_bcd;
  logic        value_valid, commit_tick, error_tick, greset, timeout_tick;
  logic [2:0]  entry_count, flags;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_cmd_decoder #(.NUM_DIGITS(ND), .MAX_VALUE(MAXV), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .reset(reset), .rx_tick(rx_tick), .din(din),
    .value_bcd(value_bcd), .value_valid(value_valid), .commit_tick(commit_tick),
    .error_tick(error_tick), .entry_count(entry_count), .flags(flags),
    .greset(greset), .timeout_tick(timeout_tick)
  );

  // clock / watchdog
  initial forever #5 CLK = ~CLK;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int   m_entry, m_cnt, m_value, m_tcnt;
  bit   m_valid, m_commit, m_error, m_greset, m_tmo, m_brk, m_ext;
  logic [2:0] m_flags;

  logic [22:0] obs;
  assign obs = {value_bcd, value_valid, commit_tick, error_tick, entry_count,
                flags, greset, timeout_tick};

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [22:0] exp_vec();
    return {to_bcd(m_value), m_valid, m_commit, m_error, 3'(m_cnt), m_flags,
            m_greset, m_tmo};
  endfunction

  task automatic model_reset();
    m_entry = 0; m_cnt = 0; m_value = 0; m_tcnt = 0;
    m_valid = 0; m_commit = 0; m_error = 0; m_greset = 0; m_tmo = 0;
    m_brk = 0; m_ext = 0; m_flags = 3'b000;
  endtask

  task automatic model_key(input logic [7:0] b, input bit ext);
    int d;
    d = digit_of(b);
    if (b == 8'h5A) begin
      if (m_cnt > 0) begin
        if (m_entry <= MAXV) begin
          m_value = m_entry; m_valid = 1; m_commit = 1;
        end else m_error = 1;
        m_entry = 0; m_cnt = 0;
      end
    end else if (ext) begin
    end else if (d >= 0) begin
      if (m_cnt == ND) m_error = 1;
      else begin m_entry = m_entry * 10 + d; m_cnt++; end
    end else begin
      case (b)
        8'h66: if (m_cnt > 0) begin m_entry = m_entry / 10; m_cnt--; end
        8'h76: begin m_entry = 0; m_cnt = 0; end
        8'h4D: m_flags[2] = ~m_flags[2];
        8'h1C: m_flags[1] = ~m_flags[1];
        8'h34: m_flags[0] = ~m_flags[0];
        8'h2D: begin m_greset = 1; m_flags = 3'b000; m_entry = 0; m_cnt = 0; end
        default: ;
      endcase
    end
  endtask

  // One clock edge of the model with the given byte strobe.
  task automatic model_edge(input bit rx, input logic [7:0] b);
    bit make, ext;
    make = 0; ext = 0;
    m_commit = 0; m_error = 0; m_greset = 0; m_tmo = 0;
    if (rx) begin
      if (m_brk) m_brk = 0;
      else if (m_ext) begin
        m_ext = 0;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'h5A) begin make = 1; ext = 1; end
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else make = 1;
    end
    if (make) begin
      model_key(b, ext);
      m_tcnt = 0;
    end
`ifdef ENTRY_TIMEOUT_EN
    else if (m_cnt > 0 && m_tcnt == TMO - 1) begin
      m_entry = 0; m_cnt = 0; m_tmo = 1;
    end else if (m_cnt > 0) m_tcnt++;
`endif
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the next falling edge with rx_tick
  // still high so a following call produces back-to-back bytes.
  task automatic tick_byte(input logic [7:0] b);
    rx_tick = 1'b1;
    din = b;
    @(negedge CLK);
    model_edge(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_tick = 1'b0;
      din = 8'($urandom);
      @(negedge CLK);
      model_edge(1'b0, 8'h00);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    rx_tick = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
  endtask

  task automatic test_commit();
    logic [7:0] s[$] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h5A, 8'hF0, 8'h5A};
    int commits = 0;
    foreach (s[i]) begin
      tick_byte(s[i]);
      commits += int'(commit_tick);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL commit step %0d: got %h expected %h", i, obs, exp_vec());
      end
      idle(1);
    end
    n_checks++;
    if (value_bcd !== 12'h012 || value_valid !== 1'b1 || commits != 1) begin
      n_fail++;
      $display("FAIL commit_012: got value %h valid %b commits %0d expected 012 1 1",
               value_bcd, value_valid, commits);
    end
  endtask

  task automatic test_range();
    logic [7:0] s[$] = '{8'h16, 8'h26, 8'h26, 8'h5A, 8'h16, 8'h1E, 8'h26, 8'h1E};
    int errs = 0;
    foreach (s[i]) begin
      tick_byte(s[i]);
      errs += int'(error_tick);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL range step %0d: got %h expected %h", i, obs, exp_vec());
      end
      idle(1);
      if (i == 3) begin
        n_checks++;
        if (errs != 1 || value_bcd !== 12'h012) begin
          n_fail++;
          $display("FAIL range_reject: got errs %0d value %h expected 1 012", errs, value_bcd);
        end
      end
    end
    n_checks++;
    if (errs != 2 || entry_count !== 3'd3) begin
      n_fail++;
      $display("FAIL digit_overflow: got errs %0d count %0d expected 2 3", errs, entry_count);
    end
    tick_byte(8'h76);
    idle(1);
  endtask

  task automatic test_backspace_ext();
    logic [7:0] s[$] = '{8'h16, 8'h1E, 8'h66, 8'h26, 8'h5A,
                         8'h16, 8'h1E, 8'h66, 8'h26, 8'hE0, 8'h5A,
                         8'hE0, 8'hF0, 8'h5A};
    int commits = 0;
    foreach (s[i]) begin
      tick_byte(s[i]);
      commits += int'(commit_tick);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL bksp_ext step %0d: got %h expected %h", i, obs, exp_vec());
      end
      idle(1);
    end
    n_checks++;
    if (value_bcd !== 12'h013 || commits != 2 || entry_count !== 3'd0) begin
      n_fail++;
      $display("FAIL bksp_ext_result: got value %h commits %0d count %0d expected 013 2 0",
               value_bcd, commits, entry_count);
    end
  endtask

  task automatic test_flags();
    logic [7:0] s[$] = '{8'h4D, 8'hF0, 8'h4D, 8'h1C};
    int gres = 0;
    foreach (s[i]) begin
      tick_byte(s[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL flags step %0d: got %h expected %h", i, obs, exp_vec());
      end
      idle(1);
    end
    n_checks++;
    if (flags !== 3'b110) begin
      n_fail++;
      $display("FAIL flags_110: got %b expected 110", flags);
    end
    tick_byte(8'h2D);
    gres = int'(greset);
    idle(1);
    n_checks++;
    if (gres != 1 || greset !== 1'b0 || flags !== 3'b000 || value_bcd !== 12'h013
        || value_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL greset: got pulse %0d after %b flags %b value %h expected 1 0 000 013",
               gres, greset, flags, value_bcd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$] = '{8'h26, 8'h25, 8'h5A, 8'h45, 8'h45, 8'h45, 8'h45, 8'h66, 8'h5A};
    foreach (s[i]) begin
      tick_byte(s[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    idle(1);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL back_to_back_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[$] = '{8'hF0, 8'hE0, 8'h5A, 8'h5A, 8'h66, 8'h76, 8'h4D, 8'h1C,
                            8'h34, 8'h2D};
    logic [7:0] b;
    int r;
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      b = dig_codes[$urandom_range(0, 9)];
      else if (r < 90) b = pool[$urandom_range(0, pool.size() - 1)];
      else             b = 8'($urandom);
      tick_byte(b);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random step %0d byte %h: got %h expected %h", i, b, obs, exp_vec());
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);
  endtask

  task automatic test_reset_coincident();
    tick_byte(8'h16);
    idle(1);
    reset = 1'b1;
    rx_tick = 1'b1;
    din = 8'h1E;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    rx_tick = 1'b0;
    model_reset();
    n_checks++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_with_rx: got %h expected 0", obs);
    end
    idle(1);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_with_rx_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

`ifdef ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    tick_byte(8'h16);
    idle(TMO - 1);
    n_checks++;
    if (timeout_tick !== 1'b0 || entry_count !== 3'd1) begin
      n_fail++;
      $display("FAIL timeout_early: got tick %b count %0d expected 0 1", timeout_tick, entry_count);
    end
    idle(1);
    n_checks++;
    if (timeout_tick !== 1'b1 || entry_count !== 3'd0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_fire: got %h expected %h", obs, exp_vec());
    end
    idle(1);
    n_checks++;
    if (timeout_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width: got %b expected 0", timeout_tick);
    end
  endtask
`endif

  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_commit();
    test_range();
    test_backspace_ext();
    test_flags();
    test_back_to_back();
    test_random();
    test_reset_coincident();
`ifdef ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_decoder.md
Name: ps2_cmd_decoder

Overview:
Parametrised successor to the current scancode interpreter. Consumes PS/2 set-2 bytes from the PS/2 receiver and handles break (F0) and extended (E0) prefixes internally, so no separate filter stage is needed. Assembles an N-digit decimal entry and commits it on Enter, with range checking. Maintains the Peligro/Alerta/Gas flags and the FSM reset pulse. Sits between the PS/2 receiver and the temperature digit decoder.

Parameters:
NUM_DIGITS, 3, number of BCD digits in the entry/committed value (1..4)
MAX_VALUE, 125, largest committable decimal value; larger entries are rejected
TIMEOUT_CYCLES, 500000000, idle cycles before a partial entry is discarded (optional feature only)

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_tick  in  1  one-cycle strobe: din holds a new scancode byte
din  in  8  scancode byte
value_bcd  out  4*NUM_DIGITS  last committed value, BCD, most significant digit in the top nibble
value_valid  out  1  high once any value has been committed
commit_tick  out  1  one-cycle pulse when value_bcd updates
error_tick  out  1  one-cycle pulse on a rejected commit or a digit overflow
entry_count  out  3  digits currently held in the working entry
flags  out  3  [2]=Peligro, [1]=Alerta, [0]=Gas
greset  out  1  one-cycle FSM reset pulse
timeout_tick  out  1  one-cycle pulse when a partial entry times out

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high and wins over rx_tick in the same cycle.
- Reset values: every output is 0, working entry is 0, prefix FSM is in P_IDLE.
- Latency: all outputs change on the edge after the rx_tick cycle. Ticks are exactly one cycle wide. Bytes arriving while rx_tick=0 are ignored.
- Prefix FSM, acting only on rx_tick:
  - P_IDLE: F0 -> P_BREAK; E0 -> P_EXT; any other byte -> make code, interpreted.
  - P_BREAK: the byte is consumed without action -> P_IDLE.
  - P_EXT: F0 -> P_BREAK; 5A (keypad Enter) -> treated as Enter -> P_IDLE; any other byte is ignored -> P_IDLE.
- Make-code actions:
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 = 0..9. The digit shifts into the working entry from the right and entry_count increments.
  - Digit when entry_count==NUM_DIGITS: digit dropped, error_tick, entry unchanged.
  - 66 Backspace: shift the entry right and decrement entry_count. No-op when entry_count==0.
  - 76 Esc: clear entry and entry_count.
  - 5A Enter with entry_count==0: ignored.
  - 5A Enter otherwise: the entry is right-aligned with leading zeros. If it is <= MAX_VALUE, it goes to value_bcd, with commit_tick and value_valid=1. If not, error_tick and value_bcd is held. The entry is cleared in both cases.
  - 4D P, 1C A, 34 G: toggle flags[2], flags[1], flags[0] respectively.
  - 2D R: greset pulse, flags cleared, entry cleared. value_bcd and value_valid are retained.
  - All other codes are ignored.
- Range compare: done digit-wise on BCD with no binary conversion. MAX_VALUE is converted to BCD at elaboration.
- Repeats: typematic make repeats without a break are each treated as a fresh keypress.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined:
  - A counter resets on every accepted make code and runs while entry_count>0.
  - When it reaches TIMEOUT_CYCLES-1, the entry is cleared and timeout_tick pulses.
  - The counter saturates until the next key.
- Undefined: no counter is built and timeout_tick is tied to 0.

Decomposition:
- Package ps2_cmd_pkg holds:
  - scancode localparams (SC_BREAK, SC_EXT, SC_ENTER, SC_BKSP, SC_ESC, SC_P, SC_A, SC_G, SC_R, digit codes)
  - the prefix FSM state encoding
  - a function mapping a scancode to {is_digit, digit}
- Sub-module ps2_prefix_fsm: takes rx_tick/din, outputs make_tick, make_code and is_ext.

Test Plan:
- reset asserted for 2 cycles -> all outputs 0 and entry_count=0.
- Bytes 16,F0,16,1E,F0,1E,5A,F0,5A -> value_bcd=0x012 with NUM_DIGITS=3, one commit_tick, value_valid=1.
- Bytes 16,26,26,5A (entry 133 > MAX_VALUE 125) -> error_tick, value_bcd unchanged. A fourth digit after 1,2,3 -> error_tick, entry_count stays 3.
- 16,1E,66,26,5A -> value 0x013. E0,5A used as Enter gives the same result. E0,F0,5A -> no action.
- 4D,F0,4D,1C -> flags=3'b110. Then 2D -> greset pulse, flags=000, value_bcd retained.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=100: byte 16, then 100 idle cycles -> timeout_tick and entry_count=0. rx_tick coincident with reset -> reset state, byte discarded.
